// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//   APB requester for the peripheral extender bus. Each command taken on the
//   valid/ready command port becomes exactly one APB transfer:
//     - one SETUP cycle
//     - ACCESS cycles until the completer raises apb_rready, or until the
//       wait-state limit aborts the transfer
//   The read data (or a timeout flag) is then offered on the valid/ready
//   response port. At most one command is in flight at a time.
//
// Parameters
//   ADDR_WIDTH      width of cmd_addr / apb_addr
//   TIMEOUT_CYCLES  ACCESS cycles with apb_rready low before abort (0 = never)
//
// Ports
//   clock, reset                     single clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (ready only in IDLE)
//   cmd_write/addr/wdata/strb        command payload
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata, rsp_timeout           response payload
//   apb_addr/sel/write/ena/wdata/pstb  APB request signals (all registered)
//   apb_rdata, apb_rready            APB completer return signals
// ---------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] apb_addr,
    output logic                  apb_sel,
    output logic                  apb_write,
    output logic                  apb_ena,
    output logic [31:0]           apb_wdata,
    output logic [3:0]            apb_pstb,
    input  logic [31:0]           apb_rdata,
    input  logic                  apb_rready
);

    // A zero-width counter is illegal, so the no-timeout build keeps one bit.
    localparam int CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit TO_EN   = (TIMEOUT_CYCLES != 0);
    // The abort fires on the wait cycle that would bring the count to the limit,
    // so the comparison is against limit-1 while apb_rready is still low.
    localparam int LIMIT_I = TO_EN ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(LIMIT_I);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // Wait counter saturates instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign cmd_ready = (state == IDLE) & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            apb_addr    <= '0;
            apb_sel     <= 1'b0;
            apb_write   <= 1'b0;
            apb_ena     <= 1'b0;
            apb_wdata   <= '0;
            apb_pstb    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready is implied here: reset is low and state is IDLE.
                    if (cmd_valid) begin
                        apb_addr  <= cmd_addr;
                        apb_write <= cmd_write;
                        apb_wdata <= cmd_write ? cmd_wdata : 32'd0;
                        apb_pstb  <= cmd_write ? cmd_strb : 4'd0;
                        apb_sel   <= 1'b1;
                        apb_ena   <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    apb_ena <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    // Completion is tested first so a ready on the limit cycle wins.
                    if (apb_rready) begin
                        rsp_rdata   <= apb_write ? 32'd0 : apb_rdata;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        apb_sel     <= 1'b0;
                        apb_ena     <= 1'b0;
                        state       <= RESP;
                    end else if (TO_EN && (wait_cnt == LIMIT)) begin
                        rsp_rdata   <= 32'd0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        apb_sel     <= 1'b0;
                        apb_ena     <= 1'b0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= sat_inc(wait_cnt);
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//   Self-checking bench for apb_master_bridge (TIMEOUT_CYCLES = 16). A small
//   completer model drives apb_rready/apb_rdata with a chosen number of wait
//   states. Expected results come from the transfer rules: a transfer with W
//   wait states completes after W+1 ACCESS cycles, unless W reaches the limit,
//   in which case it aborts after exactly TO ACCESS cycles with a timeout.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_timeout;
    logic [AW-1:0] apb_addr;
    logic          apb_sel;
    logic          apb_write;
    logic          apb_ena;
    logic [31:0]   apb_wdata;
    logic [3:0]    apb_pstb;
    logic [31:0]   apb_rdata;
    logic          apb_rready;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    apb_master_bridge #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .apb_addr   (apb_addr),
        .apb_sel    (apb_sel),
        .apb_write  (apb_write),
        .apb_ena    (apb_ena),
        .apb_wdata  (apb_wdata),
        .apb_pstb   (apb_pstb),
        .apb_rdata  (apb_rdata),
        .apb_rready (apb_rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // One complete command: accept, SETUP, ACCESS with `waits` low-ready
    // cycles, then `rdly` cycles of rsp_ready low before the handshake.
    task automatic run_txn(input logic wr, input logic [AW-1:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input logic [31:0] rd, input int waits, input int rdly);
        logic        exp_to;
        int          exp_ena;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        logic [3:0]  exp_st;
        int          ena_cnt;
        logic        stable_ok;
        logic        hold_ok;

        exp_to  = (waits >= TO);
        exp_ena = exp_to ? TO : waits + 1;
        exp_rd  = (exp_to || wr) ? 32'd0 : rd;
        exp_wd  = wr ? wdata : 32'd0;
        exp_st  = wr ? strb : 4'd0;

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        check("cmd_ready_idle", cmd_ready, 1);
        tick();

        // Payload changes after accept must not reach the bus.
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        cmd_write = ~wr;
        check("setup_sel_ena", {apb_sel, apb_ena}, 2'b10);
        check("setup_addr", apb_addr, addr);
        check("setup_write", apb_write, wr);
        check("setup_wdata", apb_wdata, exp_wd);
        check("setup_pstb", apb_pstb, exp_st);
        check("busy_cmd_ready", cmd_ready, 0);

        ena_cnt   = 0;
        stable_ok = 1'b1;
        for (int c = 0; c < TO + 8; c++) begin
            tick();
            if (!apb_sel) break;
            ena_cnt++;
            if (apb_ena !== 1'b1 || apb_addr !== addr || apb_write !== wr ||
                apb_wdata !== exp_wd || apb_pstb !== exp_st || cmd_ready !== 1'b0 ||
                rsp_valid !== 1'b0)
                stable_ok = 1'b0;
            apb_rready = (ena_cnt > waits);
            apb_rdata  = apb_rready ? rd : $urandom;
        end
        apb_rready = 1'b0;
        apb_rdata  = $urandom;

        check("access_cycles", ena_cnt, exp_ena);
        check("access_stable", stable_ok, 1);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_timeout", rsp_timeout, exp_to);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("resp_sel_ena", {apb_sel, apb_ena}, 2'b00);

        hold_ok = 1'b1;
        for (int d = 0; d < rdly; d++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_timeout !== exp_to ||
                cmd_ready !== 1'b0 || apb_sel !== 1'b0 || apb_addr !== addr)
                hold_ok = 1'b0;
        end
        check("rsp_hold", hold_ok, 1);

        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("rsp_done", rsp_valid, 0);
        check("cmd_ready_after", cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic quiet_ok;

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        cmd_strb   = '0;
        rsp_ready  = 1'b0;
        apb_rdata  = '0;
        apb_rready = 1'b0;

        tick();
        tick();
        check("reset_cmd_ready", cmd_ready, 0);
        check("reset_apb", {apb_sel, apb_ena, apb_write, apb_pstb}, 7'd0);
        check("reset_addr_wdata", {apb_addr, apb_wdata}, 64'd0);
        check("reset_rsp", {rsp_valid, rsp_timeout}, 2'b00);
        check("reset_rdata", rsp_rdata, 0);
        reset = 1'b0;
        #1;
        check("post_reset_ready", cmd_ready, 1);
        @(negedge clock);

        // Write, no wait states.
        run_txn(1'b1, 32'h20, 32'h0000_0003, 4'hF, 32'h1234_5678, 0, 0);
        // Read, no wait states.
        run_txn(1'b0, 32'h04, 32'hAAAA_5555, 4'hA, 32'hDEAD_BEEF, 0, 0);
        // Read with three wait states.
        run_txn(1'b0, 32'h100, 32'h0, 4'h0, 32'hCAFE_F00D, 3, 0);
        // Stuck completer: timeout, then a normal transfer.
        run_txn(1'b0, 32'h200, 32'h0, 4'h0, 32'h1111_2222, 40, 0);
        run_txn(1'b1, 32'h204, 32'h3333_4444, 4'h5, 32'h0, 0, 0);
        // Ready on the limit cycle completes; one more wait times out.
        run_txn(1'b0, 32'h300, 32'h0, 4'h0, 32'h5555_6666, TO - 1, 0);
        run_txn(1'b1, 32'h304, 32'h7777_8888, 4'h3, 32'h0, TO, 0);
        // Consumer back-pressure.
        run_txn(1'b0, 32'h400, 32'h0, 4'h0, 32'h9999_AAAA, 1, 5);

        // Reset in the middle of ACCESS.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h500;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("mid_access_ena", apb_ena, 1);
        reset = 1'b1;
        tick();
        check("rst_mid_sel_ena", {apb_sel, apb_ena}, 2'b00);
        check("rst_mid_rsp", rsp_valid, 0);
        check("rst_mid_cmd_ready", cmd_ready, 0);
        reset = 1'b0;
        #1;
        check("rst_mid_ready_after", cmd_ready, 1);
        @(negedge clock);
        apb_rready = 1'b1;
        quiet_ok   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || apb_sel !== 1'b0) quiet_ok = 1'b0;
        end
        apb_rready = 1'b0;
        check("no_stale_rsp", quiet_ok, 1);
        run_txn(1'b0, 32'h504, 32'h0, 4'h0, 32'hBEEF_0001, 2, 1);

        // Randomized transfers.
        for (int n = 0; n < 30; n++) begin
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom,
                    $urandom_range(0, 20), $urandom_range(0, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
